pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM).

---
 rtl/pipeline_hazard_ctrl_if.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// master: datapath side (reports hazard sources, consumes stall/flush strobes).
// slave : hazard sequencer side.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_write;
  logic       if_id_hold;
  logic       if_id_flush;
  logic       id_ex_hold;
  logic       id_ex_flush;
  logic       ex_mem_hold;
  logic       mem_err;
  logic [1:0] state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_err, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_err, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Handles load-use stalls, taken-branch flushes and data-memory waits with a
// sticky timeout error. Strobes are combinational from state + inputs so every
// hazard is answered in the cycle it is seen.
// Optional feature: define HAZ_PERF_CNT_EN to add saturating stall/flush
// performance counters (perf_stall_cnt, perf_flush_cnt).
module pipeline_hazard_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned MEM_TIMEOUT    = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_ERROR    = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] FLUSH_INIT  = CNT_W'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               MULTI_FLUSH = (BRANCH_PENALTY > 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_mem_err;
  logic             w_err_nxt;

  logic w_lu;
  logic w_memstall;
  logic w_branch;

  logic w_pc_write;
  logic w_if_id_hold;
  logic w_if_id_flush;
  logic w_id_ex_hold;
  logic w_id_ex_flush;
  logic w_ex_mem_hold;

  // Hazard detection terms
  assign w_lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  assign w_memstall = bus.mem_req && !bus.mem_ready;
  assign w_branch   = bus.ex_branch_taken;
  assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;

  // State, counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mem_err <= w_err_nxt;
    end
  end

  // Next-state / counter logic; priority memstall > branch > load-use
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_mem_err;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_memstall) begin
          if (r_state == ST_RUN) begin
            w_state_nxt = ST_MEM_WAIT;
            w_cnt_nxt   = CNT_ONE;
          end else if (r_cnt >= TIMEOUT_C) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          // Release cycle of a wait behaves exactly like RUN
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          if (w_branch && MULTI_FLUSH) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = FLUSH_INIT;
          end
        end
      end
      ST_FLUSH: begin
        // A stall freezes the flush countdown; a new branch restarts it
        if (!w_memstall) begin
          if (w_branch) begin
            if (MULTI_FLUSH) begin
              w_cnt_nxt = FLUSH_INIT;
            end else begin
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = '0;
            end
          end else if (r_cnt <= CNT_ONE) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
        w_err_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Stall/flush strobes for the current cycle
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_hold  = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_hold  = 1'b0;
    w_id_ex_flush = 1'b0;
    w_ex_mem_hold = 1'b0;
    if ((r_state == ST_ERROR) || w_memstall) begin
      w_pc_write    = 1'b0;
      w_if_id_hold  = 1'b1;
      w_id_ex_hold  = 1'b1;
      w_ex_mem_hold = 1'b1;
    end else if (w_branch) begin
      // A dependent instruction behind a taken branch is discarded, not stalled
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (r_state == ST_FLUSH) begin
      // ID holds a squashed slot during the penalty, so load-use is moot
      w_if_id_flush = 1'b1;
    end else if (w_lu) begin
      w_pc_write    = 1'b0;
      w_if_id_hold  = 1'b1;
      w_id_ex_flush = 1'b1;
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.if_id_hold  = w_if_id_hold;
  assign bus.if_id_flush = w_if_id_flush;
  assign bus.id_ex_hold  = w_id_ex_hold;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.ex_mem_hold = w_ex_mem_hold;
  assign bus.mem_err     = r_mem_err;
  assign bus.state       = r_state;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating counts of stalled-PC cycles and IF/ID flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (!w_pc_write && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_if_id_flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule
